// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-ported RAM between instruction
// fetch and data load/store; data wins unless instruction is starving.
// Ports: CLK/nRST; iREN/iaddr/iload/iwait (fetch); dREN/dWEN/daddr/
// dstore/dload/dwait (data); ramREN/ramWEN/ramaddr/ramstore/ramload/
// ram_ready (RAM side); ram_err (sticky grant timeout flag).
module ram_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 3,
    parameter int TIMEOUT      = 255
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [31:0]       iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [31:0]       dstore,
    output logic [31:0]       dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [31:0]       ramstore,
    input  logic [31:0]       ramload,
    input  logic              ram_ready,
    output logic              ram_err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] S_LIM = SW'(STARVE_LIMIT);
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    state_t        state, next_state;
    logic [SW-1:0] starve_cnt;
    logic [7:0]    tmo_cnt;
    logic          dpend;
    logic          tmo_hit;
    logic          complete;
    logic          timeout;

    assign dpend   = dREN | dWEN;
    assign iload   = ramload;
    assign dload   = ramload;
    assign tmo_hit = (tmo_cnt == TMO_LAST) && !ram_ready;

    always_comb begin
        next_state = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = iREN;
        dwait      = dpend;
        complete   = 1'b0;
        timeout    = 1'b0;
        unique case (state)
            IDLE: begin
                if (dpend && (!iREN || starve_cnt < S_LIM))
                    next_state = DGRANT;
                else if (iREN)
                    next_state = IGRANT;
            end
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iwait   = ~ram_ready;
                if (!iREN) begin
                    next_state = IDLE;
                end else if (ram_ready) begin
                    next_state = IDLE;
                    complete   = 1'b1;
                end else if (tmo_hit) begin
                    next_state = IDLE;
                    timeout    = 1'b1;
                end
            end
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                // a write wins when both enables are raised
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dwait    = ~ram_ready;
                if (!dpend) begin
                    next_state = IDLE;
                end else if (ram_ready) begin
                    next_state = IDLE;
                    complete   = 1'b1;
                end else if (tmo_hit) begin
                    next_state = IDLE;
                    timeout    = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            ram_err    <= 1'b0;
        end else begin
            state <= next_state;
            if (timeout)
                ram_err <= 1'b1;
            // grants are only entered from IDLE, so clearing here
            // is the same as clearing on grant entry
            if (state == IDLE)
                tmo_cnt <= '0;
            else if (!ram_ready && tmo_cnt != 8'hFF)
                tmo_cnt <= tmo_cnt + 8'd1;
            if (state == IDLE && !iREN)
                starve_cnt <= '0;
            else if (state == IGRANT && complete)
                starve_cnt <= '0;
            else if (state == DGRANT && complete && iREN
                     && starve_cnt < S_LIM)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed bench for ram_port_arbiter.
// Checks arbitration, starvation, withdraw, timeout and reset.
module tb_ram_port_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ram_ready;
    logic        ram_err;

    int checks = 0;
    int errors = 0;

    ram_port_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload),
        .ram_ready(ram_ready), .ram_err(ram_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        nRST = 1'b0; iREN = 1'b1; iaddr = 32'h40;
        dREN = 1'b0; dWEN = 1'b0; daddr = 32'h0; dstore = 32'h0;
        ramload = 32'h0; ram_ready = 1'b0;
        #12;
        chk("rst_ramREN", ramREN, 0);
        chk("rst_iwait", iwait, 1);
        chk("rst_err", ram_err, 0);
        chk("rst_addr", ramaddr, 0);
        nRST = 1'b1;

        // instruction grant, completes on its third cycle
        tick(); #1;
        chk("ig_ramREN", ramREN, 1);
        chk("ig_addr", ramaddr, 32'h40);
        chk("ig_iwait1", iwait, 1);
        tick(); #1;
        chk("ig_iwait2", iwait, 1);
        tick();
        ram_ready = 1'b1; ramload = 32'h8C010004;
        #1;
        chk("ig_iwait_done", iwait, 0);
        chk("ig_iload", iload, 32'h8C010004);
        chk("ig_dload", dload, 32'h8C010004);
        tick();
        ram_ready = 1'b0; iREN = 1'b0;
        #1;
        chk("idle_ramREN", ramREN, 0);
        chk("idle_iwait", iwait, 0);

        // both pending: data first, then one idle, then instruction
        iREN = 1'b1; dREN = 1'b1; daddr = 32'h100;
        tick(); #1;
        chk("dg_addr", ramaddr, 32'h100);
        chk("dg_ramREN", ramREN, 1);
        chk("dg_iwait", iwait, 1);
        chk("dg_dwait", dwait, 1);
        ram_ready = 1'b1; #1;
        chk("dg_dwait_done", dwait, 0);
        tick();
        ram_ready = 1'b0; dREN = 1'b0; #1;
        chk("gap_ramREN", ramREN, 0);
        chk("gap_iwait", iwait, 1);
        tick(); #1;
        chk("i2_ramREN", ramREN, 1);
        chk("i2_addr", ramaddr, 32'h40);
        ram_ready = 1'b1; #1;
        chk("i2_iwait", iwait, 0);
        tick();

        // starvation: D D D I repeating, ram_ready always high
        dWEN = 1'b1; dstore = 32'hDEADBEEF; daddr = 32'h200;
        for (int k = 0; k < 16; k++) begin
            tick(); #1;
            if (k % 2 == 1) begin
                chk("st_idle_wen", ramWEN, 0);
                chk("st_idle_ren", ramREN, 0);
            end else if ((k / 2) % 4 < 3) begin
                chk("st_d_wen", ramWEN, 1);
                chk("st_d_ren", ramREN, 0);
                chk("st_d_store", ramstore, 32'hDEADBEEF);
                chk("st_d_addr", ramaddr, 32'h200);
            end else begin
                chk("st_i_wen", ramWEN, 0);
                chk("st_i_ren", ramREN, 1);
                chk("st_i_addr", ramaddr, 32'h40);
            end
        end
        dWEN = 1'b0; iREN = 1'b0; ram_ready = 1'b0;

        // read+write together: write wins
        dREN = 1'b1; dWEN = 1'b1;
        tick(); #1;
        chk("rw_wen", ramWEN, 1);
        chk("rw_ren", ramREN, 0);
        ram_ready = 1'b1;
        tick();
        dWEN = 1'b0; ram_ready = 1'b0;

        // withdraw mid-grant with starve_cnt at 1
        iREN = 1'b1; dREN = 1'b1; daddr = 32'h300;
        tick();
        ram_ready = 1'b1;
        tick();
        ram_ready = 1'b0;
        tick(); #1;
        chk("wd_ren1", ramREN, 1);
        chk("wd_cnt_before", dut.starve_cnt, 1);
        tick();
        dREN = 1'b0; #1;
        chk("wd_ren_drop", ramREN, 0);
        tick();
        iREN = 1'b0; #1;
        chk("wd_idle_addr", ramaddr, 0);
        chk("wd_cnt", dut.starve_cnt, 1);
        tick();

        // timeout after 255 grant cycles without ram_ready
        dREN = 1'b1;
        tick();
        repeat (254) tick();
        #1;
        chk("to_ren_last", ramREN, 1);
        chk("to_err_pre", ram_err, 0);
        tick(); #1;
        chk("to_err", ram_err, 1);
        chk("to_dwait", dwait, 1);
        chk("to_ren_idle", ramREN, 0);
        dREN = 1'b0;
        tick(); tick(); #1;
        chk("to_sticky", ram_err, 1);

        // asynchronous reset mid-grant
        dWEN = 1'b1;
        tick(); #1;
        chk("ar_wen", ramWEN, 1);
        nRST = 1'b0; #1;
        chk("ar_wen_rst", ramWEN, 0);
        chk("ar_err_rst", ram_err, 0);
        chk("ar_dwait_rst", dwait, 1);
        dWEN = 1'b0;
        tick();
        nRST = 1'b1;
        tick(); #1;
        chk("ar_err_after", ram_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single-ported 32-bit RAM between the instruction-fetch requester and the data (load/store) requester of the datapath.
- Sequences each access with a small FSM and holds the grant until the RAM reports completion.
- Drives per-requester wait signals back toward the caches/datapath.
- Data requests have priority; a starvation counter guarantees instruction fetch progress.

Parameters:
- ADDR_W, 32, width of request and RAM addresses
- STARVE_LIMIT, 3, consecutive data grants allowed while an instruction request is pending before instruction is forced
- TIMEOUT, 255, cycles a grant may wait for ram_ready before the error flag sets

Ports:
- CLK  in  1  system clock; all state changes on rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request
- iaddr  in  ADDR_W  instruction address
- iload  out  32  instruction read data (ramload passthrough)
- iwait  out  1  instruction requester must hold request
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  ADDR_W  data address
- dstore  in  32  data write value
- dload  out  32  data read data (ramload passthrough)
- dwait  out  1  data requester must hold request
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ram_ready  in  1  RAM access completes this cycle
- ram_err  out  1  sticky timeout flag

Behaviour:
- Reset is asynchronous on nRST low, one clock CLK.
- Reset state: FSM IDLE, starve_cnt=0, tmo_cnt=0, ram_err=0.
- RAM outputs in IDLE: ramREN=ramWEN=0, ramaddr=0, ramstore=0.
- Waits in IDLE: iwait=iREN, dwait=(dREN|dWEN) (combinational).
- iload and dload always equal ramload.
- States: IDLE, IGRANT, DGRANT.
- IDLE arbitration at each edge:
  - If data is pending and (iREN==0 or starve_cnt<STARVE_LIMIT), go to DGRANT.
  - Otherwise, if iREN, go to IGRANT.
  - Otherwise stay in IDLE.
- IGRANT outputs: ramREN=iREN, ramaddr=iaddr, ramWEN=0. iwait = ~ram_ready.
- DGRANT outputs: ramaddr=daddr, ramstore=dstore.
  - If dWEN, ramWEN=1 and ramREN=0 (write has precedence when both are set).
  - Otherwise ramREN=dREN.
  - dwait = ~ram_ready.
- The non-granted requester's wait stays equal to its request.
- Completion: a grant state with ram_ready=1 goes to IDLE at the next edge. There is always one IDLE cycle between transactions, so a request still high in the completion cycle is never re-granted.
- Latency: request seen in IDLE at edge N; RAM enable asserted in cycle N+1; earliest wait deassertion is in cycle N+1.
- Request withdrawn mid-grant (granted request low, ram_ready=0):
  - RAM enables drop combinationally in the same cycle.
  - FSM returns to IDLE at the next edge.
  - starve_cnt is unchanged.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each DGRANT completion while iREN=1.
  - Clears on IGRANT completion or whenever iREN=0 in IDLE.
- tmo_cnt:
  - Clears on entry to a grant state; increments each grant cycle with ram_ready=0.
  - When it reaches TIMEOUT: ram_err<=1 (sticky until reset), FSM goes to IDLE, and the wait stays asserted.
  - 8-bit counter; no wrap, because it stops at TIMEOUT.
- Reset asserted mid-grant: outputs return to IDLE values immediately (asynchronous); no partial write is completed.
- ram_ready in IDLE is ignored.

Test Plan:
- Reset with iREN=1, iaddr=0x40 → during reset ramREN=0 and iwait=1. Release; first edge goes to IGRANT, ramaddr=0x40. ram_ready asserted 2 cycles later → iwait=0 in exactly that cycle, iload=ramload=0x8C010004.
- iREN and dREN both high at IDLE, daddr=0x100 → DGRANT first, ramaddr=0x100, iwait=1. After completion, one IDLE cycle, then IGRANT.
- iREN held high, dWEN held high continuously, ram_ready=1 every grant cycle, STARVE_LIMIT=3 → exactly 3 data writes (ramWEN=1, ramstore=dstore=0xDEADBEEF), then one instruction grant, then the pattern repeats.
- dREN=dWEN=1 → ramWEN=1, ramREN=0.
- dREN dropped in cycle 2 of DGRANT with ram_ready=0 → ramREN=0 in the same cycle, IDLE next edge, starve_cnt unchanged.
- ram_ready held 0 for 255 grant cycles → ram_err=1, FSM back to IDLE, dwait still 1. ram_err remains 1 until nRST pulses low.
